// File: rtl/dff_pipe.sv
// Elastic WIDTH x DEPTH register pipeline with valid/ready handshake, bubble collapse and flush.
// Complementary output q_b mirrors the last stage, as the single-bit dff did.
module dff_pipe #(
    parameter int unsigned      WIDTH     = 16,
    parameter int unsigned      DEPTH     = 4,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_valid,
    output logic                       d_ready,
    input  logic                       flush,
    output logic [WIDTH-1:0]           q,
    output logic [WIDTH-1:0]           q_b,
    output logic                       q_valid,
    input  logic                       q_ready,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] data_q  [DEPTH];
    logic [WIDTH-1:0] data_d  [DEPTH];
    logic [WIDTH-1:0] in_data [DEPTH];
    logic [DEPTH-1:0] v_q, v_d, adv, in_v;
    logic [CW-1:0]    count_q, count_d;

    // A stage may advance if it is empty or everything downstream of it can move.
    always_comb begin
        adv = '0;
        adv[DEPTH-1] = ~v_q[DEPTH-1] | q_ready;
        for (int i = int'(DEPTH) - 2; i >= 0; i--) begin
            adv[i] = ~v_q[i] | adv[i+1];
        end
    end

    assign d_ready = adv[0] & ~flush;

    always_comb begin
        in_v       = '0;
        in_v[0]    = d_valid & d_ready;
        in_data[0] = d;
        for (int i = 1; i < int'(DEPTH); i++) begin
            in_v[i]    = v_q[i-1];
            in_data[i] = data_q[i-1];
        end
    end

    always_comb begin
        v_d    = v_q;
        data_d = data_q;
        if (flush) begin
            v_d = '0;
        end else begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                if (adv[i]) begin
                    v_d[i] = in_v[i];
                    // Data only moves with a valid word so bubbles never toggle registers.
                    if (in_v[i]) begin
                        data_d[i] = in_data[i];
                    end
                end
            end
        end
        count_d = '0;
        for (int i = 0; i < int'(DEPTH); i++) begin
            count_d = count_d + CW'(v_d[i]);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                data_q[i] <= RESET_VAL;
            end
            v_q     <= '0;
            count_q <= '0;
        end else begin
            data_q  <= data_d;
            v_q     <= v_d;
            count_q <= count_d;
        end
    end

    assign q       = data_q[DEPTH-1];
    assign q_b     = ~data_q[DEPTH-1];
    assign q_valid = v_q[DEPTH-1];
    assign count   = count_q;

endmodule

// File: tb/tb_dff_pipe.sv
// Directed bench for dff_pipe: a DEPTH=4 instance plus a DEPTH=1 instance sharing clk and rst.
module tb_dff_pipe;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] d = '0;
    logic        d_valid = 1'b0, flush = 1'b0, q_ready = 1'b0;
    logic        d_ready, q_valid;
    logic [15:0] q, q_b;
    logic [2:0]  count;

    logic [15:0] c_d = '0;
    logic        c_dv = 1'b0, c_qr = 1'b0;
    logic        c_dr, c_qv;
    logic [15:0] c_q, c_qb;
    logic [0:0]  c_count;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    dff_pipe #(.WIDTH(16), .DEPTH(4), .RESET_VAL(16'h0000)) dut (
        .clk(clk), .rst(rst), .d(d), .d_valid(d_valid), .d_ready(d_ready), .flush(flush),
        .q(q), .q_b(q_b), .q_valid(q_valid), .q_ready(q_ready), .count(count)
    );

    dff_pipe #(.WIDTH(16), .DEPTH(1), .RESET_VAL(16'h0000)) dut1 (
        .clk(clk), .rst(rst), .d(c_d), .d_valid(c_dv), .d_ready(c_dr), .flush(1'b0),
        .q(c_q), .q_b(c_qb), .q_valid(c_qv), .q_ready(c_qr), .count(c_count)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; d_valid = 1'b1; d = 16'hABCD; q_ready = 1'b0;
        step();
        step();
        checks++; if (q !== 16'h0000) begin failures++; $display("FAIL t1_q got=%h want=0000", q); end
        checks++; if (q_b !== 16'hFFFF) begin failures++; $display("FAIL t1_q_b got=%h want=ffff", q_b); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL t1_q_valid got=%b want=0", q_valid); end
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL t1_count got=%0d want=0", count); end
        rst = 1'b0; d_valid = 1'b0;
    endtask

    task automatic test_streaming();
        logic [15:0] rx[$];
        int first_c = -1, last_c = -1;
        q_ready = 1'b1;
        for (int c = 0; c < 16; c++) begin
            if (q_valid === 1'b1) begin
                rx.push_back(q);
                if (first_c < 0) first_c = c;
                last_c = c;
            end
            if (c >= 4 && c <= 8) begin
                checks++;
                if (count !== 3'd4) begin
                    failures++; $display("FAIL t2_count cyc=%0d got=%0d want=4", c, count);
                end
            end
            d_valid = (c < 8);
            d = 16'(c + 1);
            #1;
            if (c < 8) begin
                checks++;
                if (d_ready !== 1'b1) begin
                    failures++; $display("FAIL t2_d_ready cyc=%0d got=%b want=1", c, d_ready);
                end
            end
            @(posedge clk); #1;
        end
        d_valid = 1'b0;
        checks++; if (first_c != 4) begin failures++; $display("FAIL t2_first_cycle got=%0d want=4", first_c); end
        checks++; if (last_c != 11) begin failures++; $display("FAIL t2_last_cycle got=%0d want=11", last_c); end
        for (int j = 0; j < 8; j++) begin
            checks++;
            if (j >= rx.size() || rx[j] !== 16'(j + 1)) begin
                failures++; $display("FAIL t2_word idx=%0d got=%h want=%h", j,
                                     (j < rx.size()) ? rx[j] : 16'hxxxx, 16'(j + 1));
            end
        end
    endtask

    task automatic test_backpressure();
        logic [15:0] rx[$];
        int sent = 4;
        q_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            d_valid = 1'b1; d = 16'(c + 1);
            #1;
            checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL t3_fill_ready cyc=%0d got=%b want=1", c, d_ready); end
            @(posedge clk); #1;
        end
        for (int c = 0; c < 3; c++) begin
            d_valid = 1'b1; d = 16'h0005;
            #1;
            checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL t3_full_ready cyc=%0d got=%b want=0", c, d_ready); end
            checks++; if (count !== 3'd4) begin failures++; $display("FAIL t3_count cyc=%0d got=%0d want=4", c, count); end
            checks++; if (q !== 16'h0001 || q_valid !== 1'b1) begin
                failures++; $display("FAIL t3_hold cyc=%0d got=%h/%b want=0001/1", c, q, q_valid);
            end
            @(posedge clk); #1;
        end
        q_ready = 1'b1;
        for (int c = 0; c < 20 && rx.size() < 6; c++) begin
            d_valid = (sent < 6); d = 16'(sent + 1);
            #1;
            if (q_valid === 1'b1) rx.push_back(q);
            if (d_valid && d_ready === 1'b1) sent++;
            @(posedge clk); #1;
        end
        d_valid = 1'b0;
        checks++; if (rx.size() != 6) begin failures++; $display("FAIL t3_delivered got=%0d want=6", rx.size()); end
        for (int j = 0; j < 6; j++) begin
            checks++;
            if (j >= rx.size() || rx[j] !== 16'(j + 1)) begin
                failures++; $display("FAIL t3_word idx=%0d got=%h want=%h", j,
                                     (j < rx.size()) ? rx[j] : 16'hxxxx, 16'(j + 1));
            end
        end
    endtask

    task automatic test_bubble_collapse();
        q_ready = 1'b0;
        for (int c = 0; c < 7; c++) begin
            d_valid = (c == 0 || c == 3);
            d = (c == 0) ? 16'h00AA : 16'h00BB;
            step();
        end
        d_valid = 1'b0;
        checks++; if (count !== 3'd2) begin failures++; $display("FAIL t4_count got=%0d want=2", count); end
        checks++; if (q !== 16'h00AA || q_valid !== 1'b1) begin failures++; $display("FAIL t4_head got=%h/%b want=00aa/1", q, q_valid); end
        checks++; if (d_ready !== 1'b1) begin failures++; $display("FAIL t4_d_ready got=%b want=1", d_ready); end
        q_ready = 1'b1;
        step();
        checks++; if (q !== 16'h00BB || q_valid !== 1'b1) begin failures++; $display("FAIL t4_second got=%h/%b want=00bb/1", q, q_valid); end
        step();
        checks++; if (q_valid !== 1'b0 || count !== 3'd0) begin failures++; $display("FAIL t4_drained got=%b/%0d want=0/0", q_valid, count); end
    endtask

    task automatic test_flush();
        bit seen = 1'b0;
        q_ready = 1'b0;
        for (int c = 0; c < 4; c++) begin
            d_valid = 1'b1; d = 16'(16'h0021 + c);
            step();
        end
        checks++; if (count !== 3'd4) begin failures++; $display("FAIL t5_full got=%0d want=4", count); end
        flush = 1'b1; d_valid = 1'b1; d = 16'h00EE;
        #1;
        checks++; if (d_ready !== 1'b0) begin failures++; $display("FAIL t5_flush_ready got=%b want=0", d_ready); end
        @(posedge clk); #1;
        flush = 1'b0; d_valid = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL t5_count got=%0d want=0", count); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL t5_q_valid got=%b want=0", q_valid); end
        checks++; if (q !== 16'h0021) begin failures++; $display("FAIL t5_data_kept got=%h want=0021", q); end
        q_ready = 1'b1;
        for (int c = 0; c < 6; c++) begin
            if (q_valid === 1'b1) seen = 1'b1;
            step();
        end
        checks++; if (seen !== 1'b0) begin failures++; $display("FAIL t5_leak got=%b want=0", seen); end
    endtask

    task automatic test_reset_mid();
        q_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            d_valid = 1'b1; d = 16'(16'h0031 + c);
            step();
        end
        d_valid = 1'b0;
        checks++; if (count !== 3'd3) begin failures++; $display("FAIL t6_pre_count got=%0d want=3", count); end
        rst = 1'b1;
        step();
        rst = 1'b0;
        checks++; if (count !== 3'd0) begin failures++; $display("FAIL t6_count got=%0d want=0", count); end
        checks++; if (q !== 16'h0000 || q_b !== 16'hFFFF) begin failures++; $display("FAIL t6_q got=%h/%h want=0000/ffff", q, q_b); end
        checks++; if (q_valid !== 1'b0) begin failures++; $display("FAIL t6_q_valid got=%b want=0", q_valid); end
    endtask

    task automatic test_depth1();
        c_qr = 1'b1; c_dv = 1'b1; c_d = 16'h1234;
        #1;
        checks++; if (c_dr !== 1'b1) begin failures++; $display("FAIL t7_ready got=%b want=1", c_dr); end
        @(posedge clk); #1;
        checks++; if (c_qv !== 1'b1 || c_q !== 16'h1234) begin failures++; $display("FAIL t7_w1 got=%h/%b want=1234/1", c_q, c_qv); end
        checks++; if (c_qb !== 16'hEDCB) begin failures++; $display("FAIL t7_w1_b got=%h want=edcb", c_qb); end
        checks++; if (c_count !== 1'b1) begin failures++; $display("FAIL t7_count got=%0d want=1", c_count); end
        c_d = 16'h5678;
        step();
        checks++; if (c_qv !== 1'b1 || c_q !== 16'h5678) begin failures++; $display("FAIL t7_w2 got=%h/%b want=5678/1", c_q, c_qv); end
        checks++; if (c_qb !== 16'hA987) begin failures++; $display("FAIL t7_w2_b got=%h want=a987", c_qb); end
        c_dv = 1'b0;
        step();
        checks++; if (c_qv !== 1'b0) begin failures++; $display("FAIL t7_empty got=%b want=0", c_qv); end
        c_qr = 1'b0; c_dv = 1'b1; c_d = 16'h9999;
        step();
        c_dv = 1'b0;
        #1;
        checks++; if (c_dr !== 1'b0) begin failures++; $display("FAIL t7_full_ready got=%b want=0", c_dr); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble_collapse();
        test_flush();
        test_reset_mid();
        test_depth1();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
